// File: rtl/rr_arb_mux.sv
// N-to-1 valid/ready multiplexer whose select comes from an internal round-robin
// or fixed-priority arbiter, followed by a single registered output stage.
module rr_arb_mux #(
  parameter int n        = 32,
  parameter int channels = 4,
  parameter int idxw     = (channels > 1) ? $clog2(channels) : 1
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    modeFixed,
  input  logic [channels-1:0]     inValid,
  input  logic [channels*n-1:0]   inData,
  output logic [channels-1:0]     inReady,
  output logic                    outValid,
  output logic [n-1:0]            outData,
  input  logic                    outReady,
  output logic [idxw-1:0]         grantIdx
);

  logic                load;
  logic                any_valid;
  logic [idxw-1:0]     grant_idx;
  logic [n-1:0]        grant_data;
  logic [channels-1:0] grant_oh;

  logic                out_valid_q, out_valid_d;
  logic [n-1:0]        out_data_q, out_data_d;
  logic [idxw-1:0]     grant_idx_q, grant_idx_d;
  logic [idxw-1:0]     ptr_q, ptr_d;

  // Two passes: first channels at or above the start point, then wrap from 0.
  always_comb begin : arbitrate
    int start;
    start      = 0;
    any_valid  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    grant_oh   = '0;
    if (!modeFixed) start = int'(ptr_q);
    for (int c = 0; c < channels; c++) begin
      if (!any_valid && c >= start && inValid[c]) begin
        any_valid  = 1'b1;
        grant_idx  = idxw'(c);
        grant_data = inData[c*n +: n];
        grant_oh   = channels'(1) << c;
      end
    end
    for (int c = 0; c < channels; c++) begin
      if (!any_valid && inValid[c]) begin
        any_valid  = 1'b1;
        grant_idx  = idxw'(c);
        grant_data = inData[c*n +: n];
        grant_oh   = channels'(1) << c;
      end
    end
  end

  // Gated by nReset so no producer sees an accept while the block is held in reset.
  assign load    = nReset && (!out_valid_q || outReady) && any_valid;
  assign inReady = load ? grant_oh : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      grant_idx_d = grant_idx;
      if (!modeFixed) begin
        ptr_d = (grant_idx == idxw'(channels - 1)) ? '0 : grant_idx + idxw'(1);
      end
    end else if (out_valid_q && outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign outValid = out_valid_q;
  assign outData  = out_data_q;
  assign grantIdx = grant_idx_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux (4 channels x 32 bits): reset, round-robin
// rotation, fixed priority, backpressure, pointer wrap and drain.
module tb_rr_arb_mux;

  localparam int N  = 32;
  localparam int CH = 4;
  localparam int IW = 2;

  logic              clk;
  logic              nReset;
  logic              modeFixed;
  logic [CH-1:0]     inValid;
  logic [CH*N-1:0]   inData;
  logic [CH-1:0]     inReady;
  logic              outValid;
  logic [N-1:0]      outData;
  logic              outReady;
  logic [IW-1:0]     grantIdx;

  int checks = 0;
  int errors = 0;

  rr_arb_mux #(.n(N), .channels(CH)) dut (
    .clk(clk),
    .nReset(nReset),
    .modeFixed(modeFixed),
    .inValid(inValid),
    .inData(inData),
    .inReady(inReady),
    .outValid(outValid),
    .outData(outData),
    .outReady(outReady),
    .grantIdx(grantIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] valid, input logic fixed, input logic ready);
    inValid   = valid;
    modeFixed = fixed;
    outReady  = ready;
    #1;
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic [N-1:0] data, input logic [IW-1:0] idx);
    checkOutput({tag, "_valid"}, 64'(outValid), 64'd1);
    checkOutput({tag, "_data"},  64'(outData),  64'(data));
    checkOutput({tag, "_idx"},   64'(grantIdx), 64'(idx));
  endtask

  task automatic loadDefaultData();
    for (int i = 0; i < CH; i++) inData[i*N +: N] = N'(32'h10 + i);
  endtask

  initial begin
    nReset = 1'b0;
    loadDefaultData();
    applyStimulus(4'b1111, 1'b0, 1'b1);

    // Reset state, including inReady held low with all requests up
    checkOutput("rst_valid", 64'(outValid), 64'd0);
    checkOutput("rst_data",  64'(outData),  64'd0);
    checkOutput("rst_idx",   64'(grantIdx), 64'd0);
    checkOutput("rst_ready", 64'(inReady),  64'd0);
    stepEdge();
    stepEdge();
    nReset = 1'b1;
    #1;

    // Round-robin rotation with continuous drain and load
    checkOutput("rr_first_ready", 64'(inReady), 64'b0001);
    for (int k = 0; k < 5; k++) begin
      stepEdge();
      checkBeat($sformatf("rr_%0d", k), N'(32'h10 + (k % 4)), IW'(k % 4));
    end
    // ptr now 1; load 0x12 alone, then stall with all requesting
    applyStimulus(4'b0100, 1'b0, 1'b1);
    checkOutput("bp_load_ready", 64'(inReady), 64'b0100);
    stepEdge();
    checkBeat("bp_loaded", N'(32'h12), IW'(2));
    applyStimulus(4'b1111, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("bp_ready_%0d", k), 64'(inReady), 64'd0);
      stepEdge();
      checkBeat($sformatf("bp_hold_%0d", k), N'(32'h12), IW'(2));
    end
    applyStimulus(4'b1111, 1'b0, 1'b1);
    checkOutput("bp_release_ready", 64'(inReady), 64'b1000);
    stepEdge();
    checkBeat("bp_release", N'(32'h13), IW'(3));

    // Fixed priority: channel 1 beats channel 3 while it requests
    applyStimulus(4'b1010, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("fx_ready_%0d", k), 64'(inReady), 64'b0010);
      stepEdge();
      checkBeat($sformatf("fx_%0d", k), N'(32'h11), IW'(1));
    end
    applyStimulus(4'b1000, 1'b1, 1'b1);
    checkOutput("fx_ch3_ready", 64'(inReady), 64'b1000);
    stepEdge();
    checkBeat("fx_ch3", N'(32'h13), IW'(3));

    // Back to RR from ptr 0: grant 2 moves ptr to 3, then wrap/skip on 0101
    applyStimulus(4'b0100, 1'b0, 1'b1);
    checkOutput("wr_setup_ready", 64'(inReady), 64'b0100);
    stepEdge();
    applyStimulus(4'b0101, 1'b0, 1'b1);
    checkOutput("wr_ready_0", 64'(inReady), 64'b0001);
    stepEdge();
    checkBeat("wr_0", N'(32'h10), IW'(0));
    checkOutput("wr_ready_1", 64'(inReady), 64'b0100);
    stepEdge();
    checkBeat("wr_1", N'(32'h12), IW'(2));
    checkOutput("wr_ready_2", 64'(inReady), 64'b0001);
    stepEdge();
    checkBeat("wr_2", N'(32'h10), IW'(0));

    // Drain: valid for exactly one cycle more, data retained afterwards
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("idle_ready", 64'(inReady), 64'd0);
    stepEdge();
    checkOutput("drain_valid", 64'(outValid), 64'd0);
    checkOutput("drain_data",  64'(outData),  64'h10);
    stepEdge();
    checkOutput("idle_valid", 64'(outValid), 64'd0);
    checkOutput("idle_data",  64'(outData),  64'h10);

    // Asynchronous reset mid-stream (ptr is 1 beforehand)
    inData[1*N +: N] = 32'hDEADBEEF;
    applyStimulus(4'b0010, 1'b0, 1'b0);
    stepEdge();
    checkBeat("mid_loaded", 32'hDEADBEEF, IW'(1));
    applyStimulus(4'b1111, 1'b0, 1'b0);
    #1;
    nReset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(outValid), 64'd0);
    checkOutput("mid_rst_data",  64'(outData),  64'd0);
    checkOutput("mid_rst_idx",   64'(grantIdx), 64'd0);
    checkOutput("mid_rst_ready", 64'(inReady),  64'd0);
    stepEdge();
    nReset = 1'b1;
    loadDefaultData();
    #1;
    checkOutput("post_rst_ready", 64'(inReady), 64'b0001);
    stepEdge();
    checkBeat("post_rst", N'(32'h10), IW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-to-1 data multiplexer for the datapath. Select is generated internally by an arbiter, either round-robin or fixed-priority, instead of being supplied as a select line.
- Each input channel and the output use a valid/ready handshake.
- The output is one register stage, so a selected beat appears one cycle after acceptance and is held stable under backpressure.
- Used wherever several producers share one consumer, for example memory-port sharing and writeback source selection.

Parameters:
n, 32, data width in bits per channel
channels, 4, number of input channels (>=1)
idxw, $clog2(channels) with minimum 1, width of grant index

Ports:
clk  input  1  rising-edge clock
nReset  input  1  asynchronous active-low reset
modeFixed  input  1  1 = fixed priority (channel 0 highest); 0 = round-robin
inValid  input  channels  per-channel request/valid
inData  input  channels*n  channel i occupies bits [i*n +: n]
inReady  output  channels  per-channel accept strobe (combinational)
outValid  output  1  registered output beat valid
outData  output  n  registered output data
outReady  input  1  consumer accepts the output beat
grantIdx  output  idxw  registered index of the channel whose beat is in outData

Behaviour:
- Reset (nReset=0, asynchronous):
  - outValid=0, outData=0, grantIdx=0.
  - RR pointer=0, so channel 0 has first priority.
  - Any held beat is discarded; inReady=0 while nReset=0.
- load = (!outValid || outReady) && |inValid.
- Arbitration (combinational, one-hot grant):
  - Fixed mode: lowest-index channel with inValid=1.
  - RR mode: first channel with inValid=1 searching ptr, ptr+1, ..., wrapping channels-1 -> 0.
- inReady[i] = load && grant[i]. At most one bit is set per cycle. inReady does not depend on inReady.
- On a clk edge with load=1:
  - outData <= granted channel's data; grantIdx <= granted index; outValid <= 1.
  - RR pointer <= (granted index + 1) mod channels.
- On a clk edge with load=0:
  - If outValid && outReady: outValid <= 0.
  - Otherwise all output registers hold. outData and grantIdx stay stable while outValid=1 and outReady=0.
- The pointer updates only on a load. It is unchanged with no requests or under a stall, and it is not updated in fixed mode.
- Latency: a beat accepted at edge k is visible on outputs after edge k. Full throughput is 1 beat/cycle with outReady held at 1.
- Simultaneous drain and load: outValid stays 1 and outData is replaced with the new beat. No bubble.
- Channel requirements: inValid may drop only after its inReady beat. The arbiter does not enforce this.
- Mode switch: takes effect on the next arbitration and does not disturb a held beat. Switching back to RR resumes from the stored pointer.
- channels=1: grant is always channel 0 and grantIdx is constant 0. The block behaves as a one-stage register slice.
- When no channel is valid, outData is not cleared.

Test Plan:
- Reset mid-stream: outValid=1, outData=0xDEADBEEF, nReset pulsed low between edges -> outValid=0, outData=0, grantIdx=0 immediately (asynchronous, no clock edge needed). First grant after release goes to channel 0.
- RR fairness: channels=4, modeFixed=0, all inValid=1 held, outReady=1, inData[i]=0x10+i -> outData sequence 0x10,0x11,0x12,0x13,0x10,... on consecutive cycles; grantIdx 0,1,2,3,0.
- Fixed priority: modeFixed=1, inValid=4'b1010 -> channel 1 granted every cycle; channel 3 inReady stays 0 until inValid[1] drops, then 0x13 is output.
- Backpressure: one beat 0x12 loaded, outReady=0 for 5 cycles with inValid=4'b1111 -> outData=0x12 and grantIdx=2 stable; all inReady=0; pointer unchanged. When outReady=1, channel 3 is granted in that same cycle.
- Wrap and skip: pointer=3, inValid=4'b0101 -> channel 0 granted (wrap), then channel 2, then channel 0.
- Idle/drain: single beat, outReady=1, no further inValid -> outValid high exactly 1 cycle, then 0; outData retains its last value.
